// File: rtl/traffic_phase_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : traffic_phase_ctrl
//  Purpose  : Timing and phase controller for a crossroad traffic light.
//             Divides sys_clk down to a 1 s tick and steps a four-phase
//             cycle (EW green, EW yellow, SN green, SN yellow), producing
//             per-direction countdowns for the seven-segment driver and the
//             phase code for the LED driver.
//  Ports    :
//    sys_clk   in   1  system clock
//    sys_rst_n in   1  asynchronous active-low reset
//    pause     in   1  freezes the divider, the tick and all countdowns
//    state     out  2  0=EW green, 1=EW yellow, 2=SN green, 3=SN yellow
//    ew_time   out  6  seconds remaining for the E-W direction
//    sn_time   out  6  seconds remaining for the S-N direction
//    sec_tick  out  1  one-cycle pulse at each 1 s boundary
//  Revision : 1.0  initial release
// ============================================================================
module traffic_phase_ctrl #(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int GREEN_TIME  = 27,
  parameter int YELLOW_TIME = 3
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       pause,
  output logic [1:0] state,
  output logic [5:0] ew_time,
  output logic [5:0] sn_time,
  output logic       sec_tick
);

  localparam int CNT_W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(CLK_FREQ - 1);
  localparam logic [5:0] C_GREEN  = 6'(GREEN_TIME);
  localparam logic [5:0] C_YELLOW = 6'(YELLOW_TIME);
  // Red on one side lasts as long as green+yellow on the other.
  localparam logic [5:0] C_RED    = 6'(GREEN_TIME + YELLOW_TIME);

  typedef enum logic [1:0] {
    PH_EW_GREEN  = 2'd0,
    PH_EW_YELLOW = 2'd1,
    PH_SN_GREEN  = 2'd2,
    PH_SN_YELLOW = 2'd3
  } phase_e;

  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             tick_q,  tick_d;
  phase_e           phase_q, phase_d;
  logic [5:0]       ew_q,    ew_d;
  logic [5:0]       sn_q,    sn_d;
  logic [5:0]       act_w;

  // Countdown of the direction currently holding green/yellow.
  assign act_w = ((phase_q == PH_EW_GREEN) || (phase_q == PH_EW_YELLOW)) ? ew_q : sn_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      phase_q <= PH_EW_GREEN;
      ew_q    <= C_GREEN;
      sn_q    <= C_RED;
    end else begin
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      phase_q <= phase_d;
      ew_q    <= ew_d;
      sn_q    <= sn_d;
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    tick_d  = tick_q;
    phase_d = phase_q;
    ew_d    = ew_q;
    sn_d    = sn_q;

    // While paused every register holds, so resuming continues from the
    // held count without gaining or losing a tick.
    if (!pause) begin
      tick_d = (cnt_q == C_CNT_MAX);
      cnt_d  = (cnt_q == C_CNT_MAX) ? '0 : cnt_q + 1'b1;

      if (tick_q) begin
        if (act_w != 6'd1) begin
          ew_d = ew_q - 6'd1;
          sn_d = sn_q - 6'd1;
        end else begin
          unique case (phase_q)
            PH_EW_GREEN: begin
              phase_d = PH_EW_YELLOW;
              ew_d    = C_YELLOW;
              sn_d    = sn_q - 6'd1;
            end
            PH_EW_YELLOW: begin
              phase_d = PH_SN_GREEN;
              sn_d    = C_GREEN;
              ew_d    = C_RED;
            end
            PH_SN_GREEN: begin
              phase_d = PH_SN_YELLOW;
              sn_d    = C_YELLOW;
              ew_d    = ew_q - 6'd1;
            end
            PH_SN_YELLOW: begin
              phase_d = PH_EW_GREEN;
              ew_d    = C_GREEN;
              sn_d    = C_RED;
            end
            default: begin
              phase_d = PH_EW_GREEN;
            end
          endcase
        end
      end
    end
  end

  assign state    = phase_q;
  assign ew_time  = ew_q;
  assign sn_time  = sn_q;
  assign sec_tick = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_traffic_phase_ctrl
//  Purpose  : Self-checking bench for traffic_phase_ctrl. Instance A uses
//             CLK_FREQ=10, GREEN=5, YELLOW=2; instance B uses CLK_FREQ=4,
//             GREEN=27, YELLOW=3.
//  Revision : 1.0  initial release
// ============================================================================
module tb_traffic_phase_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a_n, pause_a, rst_b_n, pause_b;
  logic [1:0] st_a, st_b;
  logic [5:0] ew_a, sn_a, ew_b, sn_b;
  logic       tk_a, tk_b;

  traffic_phase_ctrl #(.CLK_FREQ(10), .GREEN_TIME(5), .YELLOW_TIME(2)) dut_a (
    .sys_clk(clk), .sys_rst_n(rst_a_n), .pause(pause_a),
    .state(st_a), .ew_time(ew_a), .sn_time(sn_a), .sec_tick(tk_a)
  );

  traffic_phase_ctrl #(.CLK_FREQ(4), .GREEN_TIME(27), .YELLOW_TIME(3)) dut_b (
    .sys_clk(clk), .sys_rst_n(rst_b_n), .pause(pause_b),
    .state(st_b), .ew_time(ew_b), .sn_time(sn_b), .sec_tick(tk_b)
  );

  typedef struct packed {
    logic [1:0] st;
    logic [5:0] ew;
    logic [5:0] sn;
  } exp_t;

  typedef struct {
    logic pause;
    int   gap;
    exp_t exp;
  } vec_t;

  localparam int LIMIT = 200;

  vec_t vec_a[14];
  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic void check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endfunction

  function automatic exp_t mk(input int st, input int ew, input int sn);
    exp_t e;
    e.st = 2'(st);
    e.ew = 6'(ew);
    e.sn = 6'(sn);
    return e;
  endfunction

  // Reference for the 27/3 instance: display position p (0 = reset view).
  function automatic exp_t model_b(input int p);
    if (p < 27)      return mk(0, 27 - p, 30 - p);
    else if (p < 30) return mk(1, 30 - p, 30 - p);
    else if (p < 57) return mk(2, 60 - p, 57 - p);
    else             return mk(3, 60 - p, 60 - p);
  endfunction

  task automatic get(input bit b, output exp_t o, output logic tk);
    if (b) begin
      o  = {st_b, ew_b, sn_b};
      tk = tk_b;
    end else begin
      o  = {st_a, ew_a, sn_a};
      tk = tk_a;
    end
  endtask

  // Waits for the next sec_tick (counting negedges, starting from `start`),
  // checks its spacing, then compares the updated outputs one cycle later
  // against the head of the scoreboard.
  task automatic step_tick(input bit b, input int start, input int gap,
                           input string name, output exp_t got);
    int   n;
    logic tk;
    exp_t o;
    exp_t e;
    n  = start;
    tk = 1'b0;
    do begin
      @(negedge clk);
      n++;
      get(b, o, tk);
    end while (!tk && n < LIMIT);
    check({name, "_seen"}, longint'(tk), 1);
    check({name, "_period"}, longint'(n), longint'(gap));
    @(negedge clk);
    get(b, got, tk);
    if (sb_q.size() == 0) begin
      check({name, "_sb_empty"}, longint'(sb_q.size()), 1);
    end else begin
      e = sb_q.pop_front();
      check(name, longint'(got), longint'(e));
    end
  endtask

  initial begin
    exp_t o, o0, got;
    logic tk;
    bit   changed, tick_seen, zero_seen;

    // Expected view after each of the 14 ticks of one A cycle.
    vec_a[0]  = '{1'b0, 10, mk(0, 4, 6)};
    vec_a[1]  = '{1'b0, 10, mk(0, 3, 5)};
    vec_a[2]  = '{1'b0, 10, mk(0, 2, 4)};
    vec_a[3]  = '{1'b0, 10, mk(0, 1, 3)};
    vec_a[4]  = '{1'b0, 10, mk(1, 2, 2)};
    vec_a[5]  = '{1'b0, 10, mk(1, 1, 1)};
    vec_a[6]  = '{1'b0, 10, mk(2, 7, 5)};
    vec_a[7]  = '{1'b0, 10, mk(2, 6, 4)};
    vec_a[8]  = '{1'b0, 10, mk(2, 5, 3)};
    vec_a[9]  = '{1'b0, 10, mk(2, 4, 2)};
    vec_a[10] = '{1'b0, 10, mk(2, 3, 1)};
    vec_a[11] = '{1'b0, 10, mk(3, 2, 2)};
    vec_a[12] = '{1'b0, 10, mk(3, 1, 1)};
    vec_a[13] = '{1'b0, 10, mk(0, 5, 7)};

    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    pause_a = 1'b0;
    pause_b = 1'b0;
    repeat (3) @(negedge clk);

    get(0, o, tk);
    check("A_reset_vals", longint'(o), longint'(mk(0, 5, 7)));
    check("A_reset_tick", longint'(tk), 0);
    get(1, o, tk);
    check("B_reset_vals", longint'(o), longint'(mk(0, 27, 30)));

    // Two full cycles from reset release.
    rst_a_n = 1'b1;
    for (int lap = 0; lap < 2; lap++) begin
      for (int i = 0; i < 14; i++) begin
        pause_a = vec_a[i].pause;
        sb_q.push_back(vec_a[i].exp);
        step_tick(0, (lap == 0 && i == 0) ? 0 : 1, vec_a[i].gap, "A_tick", got);
      end
    end

    // Divider is at 1 here; advance to 4 and pause for 37 cycles.
    repeat (3) @(negedge clk);
    pause_a = 1'b1;
    get(0, o0, tk);
    check("A_pause_entry", longint'(o0), longint'(mk(0, 5, 7)));
    changed   = 1'b0;
    tick_seen = 1'b0;
    repeat (37) begin
      @(negedge clk);
      get(0, o, tk);
      if (o != o0) changed = 1'b1;
      if (tk)      tick_seen = 1'b1;
    end
    check("A_pause_frozen", longint'(changed), 0);
    check("A_pause_no_tick", longint'(tick_seen), 0);
    pause_a = 1'b0;
    sb_q.push_back(mk(0, 4, 6));
    step_tick(0, 0, 6, "A_resume", got);

    // Continue into SN yellow (state 3, 2/2).
    for (int i = 1; i < 12; i++) begin
      sb_q.push_back(vec_a[i].exp);
      step_tick(0, 1, 10, "A_run3", got);
    end

    // Asynchronous reset between edges while in state 3.
    repeat (2) @(negedge clk);
    #2 rst_a_n = 1'b0;
    #1 get(0, o, tk);
    check("A_async_reset", longint'(o), longint'(mk(0, 5, 7)));
    check("A_async_tick", longint'(tk), 0);
    @(negedge clk);
    rst_a_n = 1'b1;
    sb_q.push_back(vec_a[0].exp);
    step_tick(0, 0, 10, "A_restart", got);
    sb_q.push_back(vec_a[1].exp);
    step_tick(0, 1, 10, "A_restart2", got);

    // Default timing over a full 60-tick cycle plus two.
    rst_b_n   = 1'b1;
    zero_seen = 1'b0;
    for (int k = 1; k <= 62; k++) begin
      sb_q.push_back(model_b(k % 60));
      step_tick(1, (k == 1) ? 0 : 1, 4, "B_tick", got);
      if (got.ew == 6'd0 || got.sn == 6'd0) zero_seen = 1'b1;
    end
    check("B_never_zero", longint'(zero_seen), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
